// File: rtl/oflow_pkg.sv
// Shared types and defaults for the optical-flow score selection blocks.
// Defaults here must track the core SCORE_LEN / ID_LEN defines.
package oflow_pkg;

    localparam int SCORE_LEN_DEF  = 32;
    localparam int ID_LEN_DEF     = 12;
    localparam int CAND_CNT_W_DEF = 6;

    localparam logic [SCORE_LEN_DEF-1:0] SCORE_MAX = {SCORE_LEN_DEF{1'b1}};

    typedef enum logic [1:0] {
        idle_st   = 2'd0,
        search_st = 2'd1,
        done_st   = 2'd2
    } state_t;

endpackage

// File: rtl/oflow_score_cmp.sv
// Combinational best-match test: strict unsigned less-than against the current best,
// optionally gated by a maximum acceptable score (OFLOW_SCORE_THRESHOLD_EN).
module oflow_score_cmp #(
    parameter int SCORE_LEN = 32
) (
    input  logic [SCORE_LEN-1:0] score,
    input  logic [SCORE_LEN-1:0] best_score,
`ifdef OFLOW_SCORE_THRESHOLD_EN
    input  logic [SCORE_LEN-1:0] score_threshold,
`endif
    output logic                 update
);

    logic better;
    logic eligible;

    // Strict compare keeps the earliest candidate on ties.
    assign better = (score < best_score);

`ifdef OFLOW_SCORE_THRESHOLD_EN
    assign eligible = (score <= score_threshold);
`else
    assign eligible = 1'b1;
`endif

    assign update = better & eligible;

endmodule

// File: rtl/oflow_score_min_select.sv
// Minimum-score selector: consumes one score per previous-frame candidate and reports
// the best (lowest) score and its id. Optional threshold gate: OFLOW_SCORE_THRESHOLD_EN.
module oflow_score_min_select
    import oflow_pkg::*;
#(
    parameter int SCORE_LEN  = SCORE_LEN_DEF,
    parameter int ID_LEN     = ID_LEN_DEF,
    parameter int CAND_CNT_W = CAND_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_N,
    input  logic                  start,
    input  logic [CAND_CNT_W-1:0] num_of_candidates,
    input  logic                  score_valid,
    input  logic [SCORE_LEN-1:0]  score,
    input  logic [ID_LEN-1:0]     id,
`ifdef OFLOW_SCORE_THRESHOLD_EN
    input  logic [SCORE_LEN-1:0]  score_threshold,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [SCORE_LEN-1:0]  best_score,
    output logic [ID_LEN-1:0]     best_id,
    output logic                  no_match,
    output state_t                dbg_state
);

    // Stream semantics: score/id are consumed in every cycle score_valid is high while
    // searching; there is no ready, so the block accepts back-to-back strobes.
    localparam logic [CAND_CNT_W-1:0] CNT_ONE = {{(CAND_CNT_W-1){1'b0}}, 1'b1};

    state_t                state;
    logic [CAND_CNT_W-1:0] cand_cnt;
    logic [CAND_CNT_W-1:0] cand_total;
    logic                  any_update;
    logic                  update;
    logic                  last_cand;

    oflow_score_cmp #(
        .SCORE_LEN (SCORE_LEN)
    ) u_cmp (
        .score           (score),
        .best_score      (best_score),
`ifdef OFLOW_SCORE_THRESHOLD_EN
        .score_threshold (score_threshold),
`endif
        .update          (update)
    );

    assign last_cand = (cand_cnt == (cand_total - CNT_ONE));
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state      <= idle_st;
            cand_cnt   <= '0;
            cand_total <= '0;
            any_update <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            best_score <= {SCORE_LEN{1'b1}};
            best_id    <= '0;
            no_match   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                idle_st: begin
                    if (start) begin
                        cand_total <= num_of_candidates;
                        cand_cnt   <= '0;
                        any_update <= 1'b0;
                        best_score <= {SCORE_LEN{1'b1}};
                        best_id    <= '0;
                        if (num_of_candidates == '0) begin
                            state    <= done_st;
                            done     <= 1'b1;
                            no_match <= 1'b1;
                        end else begin
                            state    <= search_st;
                            busy     <= 1'b1;
                            no_match <= 1'b0;
                        end
                    end
                end
                search_st: begin
                    if (score_valid) begin
                        cand_cnt <= cand_cnt + CNT_ONE;
                        if (update) begin
                            best_score <= score;
                            best_id    <= id;
                            any_update <= 1'b1;
                        end
                        if (last_cand) begin
                            state <= done_st;
                            done  <= 1'b1;
                            busy  <= 1'b0;
`ifdef OFLOW_SCORE_THRESHOLD_EN
                            no_match <= ~(any_update | update);
`else
                            no_match <= 1'b0;
`endif
                        end
                    end
                end
                done_st: begin
                    state <= idle_st;
                end
                default: begin
                    state <= idle_st;
                end
            endcase
        end
    end

endmodule

// File: doc/oflow_score_min_select.md
Name: oflow_score_min_select

Overview:
- Sits directly downstream of the similarity-metric stage.
- For one current-frame object it consumes the stream of (score, id, valid) results, one per previous-frame candidate.
- Tracks the minimum score, i.e. the best match, and reports the winning candidate id once all candidates have been scored.
- The result feeds the ID-assignment / conflict-resolution logic.

Parameters:
- SCORE_LEN, 32, score width; q26.6 unsigned, lower is better.
- ID_LEN, 12, candidate id width.
- CAND_CNT_W, 6, width of candidate count; max candidates 2^CAND_CNT_W-1.

Ports:
- clk  in  1  clock.
- reset_N  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin search for a new current object.
- num_of_candidates  in  CAND_CNT_W  number of scores to expect; sampled on accepted start.
- score_valid  in  1  one-cycle strobe from the similarity stage; score/id valid this cycle.
- score  in  SCORE_LEN  candidate score.
- id  in  ID_LEN  candidate id.
- score_threshold  in  SCORE_LEN  max acceptable score; present only with OFLOW_SCORE_THRESHOLD_EN.
- busy  out  1  high in search_st.
- done  out  1  one-cycle pulse; result valid.
- best_score  out  SCORE_LEN  minimum score seen; held until next accepted start.
- best_id  out  ID_LEN  id of minimum score; held.
- no_match  out  1  set with done when no acceptable candidate exists; held.

Behaviour:
- Clock and reset: single clock clk; reset_N asynchronous active-low.
- Reset values:
  - busy=0, done=0, best_score=all ones, best_id=0, no_match=0.
  - FSM in idle_st, cand_cnt=0.
- FSM states: idle_st, search_st, done_st.
- idle_st:
  - start=1 latches num_of_candidates into cand_total, loads best_score=all ones, best_id=0, no_match=0 and cand_cnt=0.
  - If the latched count is 0: go to done_st.
  - Otherwise: go to search_st.
  - score_valid in idle_st is ignored.
- search_st:
  - On each score_valid, cand_cnt increments.
  - If score < best_score (strict), best_score<=score and best_id<=id.
  - Ties keep the earlier candidate (lowest arrival order).
  - When score_valid arrives with cand_cnt==cand_total-1, the compare is applied and the FSM goes to done_st next cycle.
  - start during search_st is ignored; no restart.
- done_st:
  - Lasts exactly one cycle; done=1; returns to idle_st.
  - no_match=1 if cand_total==0 (best_score stays all ones, best_id=0).
  - start arriving in done_st is ignored; the upstream controller must start on or after the cycle following done.
- Latency: done asserts exactly 1 cycle after the last score_valid. For a zero-candidate start, done asserts 1 cycle after start.
- Outputs are registered; best_score/best_id are stable from the done cycle until the next accepted start.
- Comparison is unsigned, full SCORE_LEN; no saturation or rounding.
- cand_cnt is CAND_CNT_W bits and cannot wrap, since cand_total ≤ 2^CAND_CNT_W-1.
- Reset asserted mid-search: immediate return to reset values; partial result discarded; no done pulse.
- score_valid in consecutive cycles must be accepted every cycle (no back-pressure). The similarity stage produces at most one score per 5 cycles, but the block must not rely on that.

Optional Feature:
- Macro: OFLOW_SCORE_THRESHOLD_EN.
- Defined:
  - score_threshold port exists.
  - A candidate updates best only if score < best_score AND score <= score_threshold.
  - If no candidate qualifies, done asserts with no_match=1, best_score=all ones, best_id=0.
- Undefined:
  - Port absent; every candidate is eligible.
  - no_match is set only for zero candidates.

Decomposition:
- Shared package oflow_pkg:
  - Typedef of the FSM state enum {idle_st, search_st, done_st}.
  - SCORE_LEN/ID_LEN defaults, kept consistent with the core defines.
  - Constant SCORE_MAX = all ones.
- One natural sub-module: oflow_score_cmp, the combinational eligibility/less-than compare, including the threshold gate under the macro.
- Counter and FSM stay in the top.

Test Plan:
- start, num=3; scores 500@id7, 200@id3, 900@id9 → done 1 cycle after third valid; best_score=200, best_id=3, no_match=0.
- start, num=3; scores 300@id1, 300@id2, 400@id4 → best_id=1 (tie keeps first).
- start, num=0 → done 1 cycle after start; no_match=1, best_score=0xFFFFFFFF, best_id=0.
- start, num=4; score_valid on 4 consecutive cycles with 40, 30, 20, 10 @ ids 1..4 → best_id=4, best_score=10; start pulsed mid-search is ignored.
- start, num=3; reset_N low after 2 scores → outputs at reset values, no done; a fresh start with num=1, score 5@id2 → best_id=2.
- With OFLOW_SCORE_THRESHOLD_EN, threshold=100; scores 150, 120 → no_match=1, best_id=0. Then threshold=130 with the same scores → best_score=120.
